// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// instruction decode, memory-wait watchdog, halt/fault states and retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 32,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       opecode,
  input  logic [5:0]       funct,
  input  logic             zflag,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [5:0]       alu_func,
  output logic             reorim,
  output logic [1:0]       cp_type,
  output logic             enbranch,
  output logic             write_reg,
  output logic             write_pc,
  output logic             write_lr,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam logic [5:0]  OP_ADDI  = 6'b001000;
  localparam logic [5:0]  OP_SLTI  = 6'b001010;
  localparam logic [5:0]  OP_ANDI  = 6'b001100;
  localparam logic [5:0]  OP_ORI   = 6'b001101;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  FN_JR    = 6'b001000;
  localparam logic [15:0] WAIT_MAX = 16'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       fn_q, fn_d;
  logic             enbranch_q, enbranch_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       is_branch, is_lw, is_sw, is_jal, is_jr;
  logic [5:0] dec_alu;
  logic       dec_reorim, dec_wreg;
  logic [1:0] dec_cp;

  always_comb begin
    is_branch  = (op_q == OP_BEQ) || (op_q == OP_BNE);
    is_lw      = (op_q == OP_LW);
    is_sw      = (op_q == OP_SW);
    is_jal     = (op_q == OP_JAL);
    is_jr      = (op_q == OP_RTYPE) && (fn_q == FN_JR);
    dec_alu    = 6'b000000;
    dec_reorim = 1'b0;
    dec_wreg   = 1'b0;
    dec_cp     = 2'b00;
    case (op_q)
      OP_RTYPE: begin dec_alu = fn_q; dec_wreg = !is_jr; dec_cp = is_jr ? 2'b01 : 2'b00; end
      OP_ADDI:  begin dec_alu = 6'b100000; dec_reorim = 1'b1; dec_wreg = 1'b1; end
      OP_ANDI:  begin dec_alu = 6'b100100; dec_reorim = 1'b1; dec_wreg = 1'b1; end
      OP_ORI:   begin dec_alu = 6'b100101; dec_reorim = 1'b1; dec_wreg = 1'b1; end
      OP_SLTI:  begin dec_alu = 6'b101010; dec_reorim = 1'b1; dec_wreg = 1'b1; end
      OP_BEQ,
      OP_BNE:   begin dec_alu = 6'b100010; dec_reorim = 1'b1; dec_cp = 2'b11; end
      OP_LW:    begin dec_alu = 6'b100000; dec_reorim = 1'b1; dec_wreg = 1'b1; end
      OP_SW:    begin dec_alu = 6'b100000; dec_reorim = 1'b1; end
      OP_J,
      OP_JAL:   dec_cp = 2'b10;
      default:  ;
    endcase
  end

  // An ack arriving on the last allowed wait cycle wins over the watchdog.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    op_d       = op_q;
    fn_d       = fn_q;
    enbranch_d = enbranch_q;
    instret_d  = instret_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = 16'd0;
      end
      S_FETCH: begin
        if (imem_ack)                state_d = S_DECODE;
        else if (wait_q == WAIT_MAX) state_d = S_FAULT;
        else                         wait_d  = wait_q + 16'd1;
      end
      S_DECODE: begin
        op_d       = opecode;
        fn_d       = funct;
        enbranch_d = 1'b0;
        state_d    = (opecode == HALT_OP) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_branch) enbranch_d = zflag ^ op_q[0];
        wait_d  = 16'd0;
        state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack)                state_d = S_WB;
        else if (wait_q == WAIT_MAX) state_d = S_FAULT;
        else                         wait_d  = wait_q + 16'd1;
      end
      S_WB: begin
        instret_d  = instret_q + CNT_W'(1);
        wait_d     = 16'd0;
        enbranch_d = 1'b0;
        state_d    = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wait_q     <= 16'd0;
      op_q       <= 6'd0;
      fn_q       <= 6'd0;
      enbranch_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      op_q       <= op_d;
      fn_q       <= fn_d;
      enbranch_q <= enbranch_d;
      instret_q  <= instret_d;
    end
  end

  // Decoded controls are only driven while the op register holds the current instruction.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_func  = 6'b000000;
    reorim    = 1'b0;
    cp_type   = 2'b00;
    write_reg = 1'b0;
    write_pc  = 1'b0;
    write_lr  = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_EXEC, S_MEM, S_WB: begin
        alu_func = dec_alu;
        reorim   = dec_reorim;
        cp_type  = dec_cp;
        if (state_q == S_MEM) begin
          dmem_req = 1'b1;
          dmem_we  = is_sw;
        end
        if (state_q == S_WB) begin
          write_pc  = 1'b1;
          write_reg = dec_wreg;
          write_lr  = is_jal;
        end
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign enbranch = enbranch_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (WAIT_LIMIT=4).
module tb_multicycle_controller;

  logic        clk;
  logic        rstn;
  logic [5:0]  opecode;
  logic [5:0]  funct;
  logic        zflag;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [5:0]  alu_func;
  logic        reorim;
  logic [1:0]  cp_type;
  logic        enbranch;
  logic        write_reg;
  logic        write_pc;
  logic        write_lr;
  logic        halted;
  logic        fault;
  logic [31:0] instret;

  int vectors;
  int miscompares;

  multicycle_controller #(
    .WAIT_LIMIT(4),
    .CNT_W(32),
    .HALT_OP(6'b111111)
  ) dut (
    .clk(clk), .rstn(rstn), .opecode(opecode), .funct(funct), .zflag(zflag),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_func(alu_func), .reorim(reorim),
    .cp_type(cp_type), .enbranch(enbranch), .write_reg(write_reg), .write_pc(write_pc),
    .write_lr(write_lr), .halted(halted), .fault(fault), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs every output except instret so idle/reset checks are one comparison.
  function automatic logic [31:0] allOutputs();
    return {12'd0, imem_req, ir_we, dmem_req, dmem_we, alu_func, reorim, cp_type,
            enbranch, write_reg, write_pc, write_lr, halted, fault};
  endfunction

  // Called in a FETCH cycle: acks at once with the given instruction, leaves the bench in EXEC.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opecode  = op;
    funct    = fn;
    zflag    = z;
    imem_ack = 1'b1;
    #1;
    checkOutput("ir_we_on_ack", ir_we, 1);
    tick();
    imem_ack = 1'b0;
    checkOutput("decode_no_req", imem_req, 0);
    tick();
  endtask

  initial begin
    vectors = 0;  miscompares = 0;
    rstn = 1'b0;  opecode = 6'd0;  funct = 6'd0;  zflag = 1'b0;
    imem_ack = 1'b0;  dmem_ack = 1'b0;
    tick();  tick();
    checkOutput("reset_outputs", allOutputs(), 0);
    checkOutput("reset_instret", instret, 0);

    rstn = 1'b1;
    #1;
    checkOutput("idle_no_req", imem_req, 0);
    tick();
    checkOutput("fetch_req", imem_req, 1);
    checkOutput("fetch_no_irwe", ir_we, 0);

    // add
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    checkOutput("add_exec_alu", alu_func, 6'b100000);
    checkOutput("add_exec_reorim", reorim, 0);
    checkOutput("add_exec_no_wreg", write_reg, 0);
    tick();
    checkOutput("add_wb_wreg", write_reg, 1);
    checkOutput("add_wb_wpc", write_pc, 1);
    checkOutput("add_wb_instret", instret, 0);
    tick();
    checkOutput("add_after_wreg", write_reg, 0);
    checkOutput("add_after_wpc", write_pc, 0);
    checkOutput("add_instret", instret, 1);
    checkOutput("add_back_fetch", imem_req, 1);

    // beq with zflag=1 -> taken
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    checkOutput("beq_exec_alu", alu_func, 6'b100010);
    checkOutput("beq_exec_reorim", reorim, 1);
    checkOutput("beq_exec_cp", cp_type, 2'b11);
    tick();
    checkOutput("beq_wb_enbranch", enbranch, 1);
    checkOutput("beq_wb_cp", cp_type, 2'b11);
    checkOutput("beq_wb_wreg", write_reg, 0);
    checkOutput("beq_wb_wpc", write_pc, 1);
    tick();
    checkOutput("beq_instret", instret, 2);

    // bne with zflag=1 -> untaken
    applyStimulus(6'b000101, 6'b000000, 1'b1);
    checkOutput("bne_exec_cp", cp_type, 2'b11);
    tick();
    checkOutput("bne_wb_enbranch", enbranch, 0);
    checkOutput("bne_wb_cp", cp_type, 2'b11);
    checkOutput("bne_wb_wreg", write_reg, 0);
    tick();
    checkOutput("bne_instret", instret, 3);

    // lw, dmem_ack on the 4th MEM cycle (also the last allowed wait cycle)
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    checkOutput("lw_exec_alu", alu_func, 6'b100000);
    checkOutput("lw_exec_reorim", reorim, 1);
    checkOutput("lw_exec_no_dreq", dmem_req, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("lw_mem%0d_dreq", i), dmem_req, 1);
      checkOutput($sformatf("lw_mem%0d_dwe", i), dmem_we, 0);
      if (i == 4) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    checkOutput("lw_wb_dreq", dmem_req, 0);
    checkOutput("lw_wb_fault", fault, 0);
    checkOutput("lw_wb_wreg", write_reg, 1);
    checkOutput("lw_wb_wpc", write_pc, 1);
    tick();
    checkOutput("lw_instret", instret, 4);

    // sw, immediate dmem_ack
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    checkOutput("sw_exec_alu", alu_func, 6'b100000);
    tick();
    checkOutput("sw_mem_dreq", dmem_req, 1);
    checkOutput("sw_mem_dwe", dmem_we, 1);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checkOutput("sw_wb_dwe", dmem_we, 0);
    checkOutput("sw_wb_wreg", write_reg, 0);
    checkOutput("sw_wb_wpc", write_pc, 1);
    tick();
    checkOutput("sw_instret", instret, 5);

    // jal
    applyStimulus(6'b000011, 6'b000000, 1'b0);
    checkOutput("jal_exec_cp", cp_type, 2'b10);
    checkOutput("jal_exec_alu", alu_func, 6'b000000);
    tick();
    checkOutput("jal_wb_wlr", write_lr, 1);
    checkOutput("jal_wb_wpc", write_pc, 1);
    checkOutput("jal_wb_wreg", write_reg, 0);
    tick();
    checkOutput("jal_after_wlr", write_lr, 0);

    // jr
    applyStimulus(6'b000000, 6'b001000, 1'b0);
    checkOutput("jr_exec_cp", cp_type, 2'b01);
    checkOutput("jr_exec_alu", alu_func, 6'b001000);
    tick();
    checkOutput("jr_wb_wreg", write_reg, 0);
    checkOutput("jr_wb_wpc", write_pc, 1);
    tick();
    checkOutput("jr_instret", instret, 7);

    // unknown opcode behaves as NOP
    applyStimulus(6'b010000, 6'b000000, 1'b0);
    checkOutput("nop_exec_alu", alu_func, 6'b000000);
    checkOutput("nop_exec_cp", cp_type, 2'b00);
    tick();
    checkOutput("nop_wb_wpc", write_pc, 1);
    checkOutput("nop_wb_wreg", write_reg, 0);
    tick();
    checkOutput("nop_instret", instret, 8);

    // ori
    applyStimulus(6'b001101, 6'b000000, 1'b0);
    checkOutput("ori_exec_alu", alu_func, 6'b100101);
    checkOutput("ori_exec_reorim", reorim, 1);
    tick();
    checkOutput("ori_wb_wreg", write_reg, 1);
    tick();
    checkOutput("ori_instret", instret, 9);

    // imem_ack on the 4th FETCH cycle still wins over the watchdog
    tick();  tick();  tick();
    checkOutput("late_ack_req", imem_req, 1);
    checkOutput("late_ack_nofault", fault, 0);
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    checkOutput("late_ack_exec_alu", alu_func, 6'b100000);
    checkOutput("late_ack_exec_nofault", fault, 0);
    tick();  tick();
    checkOutput("late_ack_instret", instret, 10);

    // no imem_ack: four wait cycles then FAULT, held
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("wd_wait%0d_fault", i), fault, 0);
      tick();
    end
    checkOutput("wd_fault", fault, 1);
    checkOutput("wd_fault_req", imem_req, 0);
    tick();  tick();  tick();
    checkOutput("wd_fault_held", allOutputs(), 32'd1);
    checkOutput("wd_instret_held", instret, 10);

    // asynchronous reset out of FAULT
    rstn = 1'b0;
    #1;
    checkOutput("rst_fault_outputs", allOutputs(), 0);
    checkOutput("rst_fault_instret", instret, 0);
    tick();
    rstn = 1'b1;
    tick();
    checkOutput("restart_fetch", imem_req, 1);

    // one add, then HALT
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    tick();  tick();
    checkOutput("pre_halt_instret", instret, 1);
    opecode  = 6'b111111;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    checkOutput("halt_outputs", allOutputs(), 32'd2);
    tick();  tick();  tick();
    checkOutput("halt_held", halted, 1);
    checkOutput("halt_no_wpc", write_pc, 0);
    checkOutput("halt_instret", instret, 1);

    // reset pulsed mid-MEM
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    tick();
    checkOutput("midmem_dreq", dmem_req, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midmem_rst_outputs", allOutputs(), 0);
    checkOutput("midmem_rst_instret", instret, 0);
    #1;
    rstn = 1'b1;
    #1;
    checkOutput("midmem_idle", imem_req, 0);
    tick();
    checkOutput("midmem_refetch", imem_req, 1);
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    tick();  tick();
    checkOutput("midmem_restart_instret", instret, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
